// File: rtl/ena_gen_pkg.sv
// Shared types and helpers for the fractional clock-enable generator.
package ena_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } ena_gen_state_t;

  localparam int ACC_W_DEF = 16;
  localparam int CNT_W_DEF = 32;

  // Rate num/den must not exceed one strobe per cycle; den of zero is meaningless.
  function automatic logic ena_gen_cfg_valid(input logic [63:0] num, input logic [63:0] den);
    return (den != 64'd0) && (num <= den);
  endfunction

endpackage

// File: rtl/ena_gen_acc.sv
// Bresenham accumulator: adds num each step, wraps by den and flags a strobe on wrap.
module ena_gen_acc #(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             step,
  input  logic [ACC_W-1:0] num,
  input  logic [ACC_W-1:0] den,
  output logic             hit
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;
  logic [ACC_W:0]   diff;

  // One extra bit keeps acc + num exact; acc < den holds so diff fits in ACC_W bits.
  assign sum  = {1'b0, acc} + {1'b0, num};
  assign diff = sum - {1'b0, den};
  assign hit  = step && (sum >= {1'b0, den});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (step) begin
      acc <= hit ? diff[ACC_W-1:0] : sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/ena_gen.sv
// Fractional clock-enable generator with double-buffered configuration.
// Optional burst limit and done pulse are enabled by defining ENA_GEN_BURST_EN.
module ena_gen
  import ena_gen_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ACC_W-1:0] cfg_num_i,
  input  logic [ACC_W-1:0] cfg_den_i,
  input  logic [15:0]      cfg_burst_i,
  input  logic             cfg_load_i,
  input  logic             run_i,
  output logic             ena_o,
  output logic             busy_o,
  output logic             err_o,
  output logic             done_o,
  output logic [CNT_W-1:0] strobe_cnt_o
);

  ena_gen_state_t   state;
  logic [ACC_W-1:0] num_q;
  logic [ACC_W-1:0] den_q;
  logic             cfg_ok;
  logic             stepping;
  logic             hit;
  logic             burst_last;

  assign cfg_ok   = ena_gen_cfg_valid(64'(cfg_num_i), 64'(cfg_den_i));
  // A load cycle never steps, so accumulation restarts from zero afterwards.
  assign stepping = (state == ST_RUN) && run_i && !cfg_load_i;
  assign busy_o   = (state == ST_RUN);
  assign err_o    = (state == ST_ERR);

  ena_gen_acc #(.ACC_W(ACC_W)) u_acc (
    .clk  (clk),
    .rst  (rst),
    .clr  (!stepping),
    .step (stepping),
    .num  (num_q),
    .den  (den_q),
    .hit  (hit)
  );

`ifdef ENA_GEN_BURST_EN
  logic [15:0] burst_q;
  logic [15:0] bcnt_q;

  assign burst_last = hit && (burst_q != 16'd0) && ((bcnt_q + 16'd1) == burst_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_q <= '0;
      bcnt_q  <= '0;
    end else if (cfg_load_i) begin
      burst_q <= cfg_burst_i;
      bcnt_q  <= '0;
    end else if (stepping) begin
      if (hit) bcnt_q <= bcnt_q + 16'd1;
    end else begin
      bcnt_q <= '0;
    end
  end
`else
  logic unused_burst;
  assign unused_burst = ^cfg_burst_i;
  assign burst_last   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      num_q        <= ACC_W'(1);
      den_q        <= ACC_W'(1);
      ena_o        <= 1'b0;
      done_o       <= 1'b0;
      strobe_cnt_o <= '0;
    end else begin
      ena_o  <= 1'b0;
      done_o <= 1'b0;
      if (cfg_load_i) begin
        num_q        <= cfg_num_i;
        den_q        <= cfg_den_i;
        strobe_cnt_o <= '0;
        if (!cfg_ok)                        state <= ST_ERR;
        else if (state == ST_RUN && run_i)  state <= ST_RUN;
        else                                state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: if (run_i) state <= ST_RUN;
          ST_RUN: begin
            if (!run_i) begin
              state <= ST_IDLE;
            end else begin
              ena_o <= hit;
              if (hit) strobe_cnt_o <= strobe_cnt_o + CNT_W'(1);
              // The final burst strobe and the move to DONE share one edge.
              if (burst_last) begin
                state  <= ST_DONE;
                done_o <= 1'b1;
              end
            end
          end
          ST_DONE: if (!run_i) state <= ST_IDLE;
          ST_ERR:  state <= ST_ERR;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ena_gen.sv
// Scoreboard bench for ena_gen against a closed-form rate model.
module tb_ena_gen;

  localparam int ACC_W = 16;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [ACC_W-1:0] cfg_num = '0;
  logic [ACC_W-1:0] cfg_den = '0;
  logic [15:0]      cfg_burst = '0;
  logic             cfg_load = 1'b0;
  logic             run = 1'b0;
  logic             ena, busy, err, done;
  logic [CNT_W-1:0] cnt;

  ena_gen #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_num_i    (cfg_num),
    .cfg_den_i    (cfg_den),
    .cfg_burst_i  (cfg_burst),
    .cfg_load_i   (cfg_load),
    .run_i        (run),
    .ena_o        (ena),
    .busy_o       (busy),
    .err_o        (err),
    .done_o       (done),
    .strobe_cnt_o (cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             ena;
    logic             busy;
    logic             err;
    logic             done;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  typedef struct {
    longint want;
    int     id;
  } cnt_chk_t;

  exp_t     sb_q[$];
  cnt_chk_t xq[$];
  int       checks = 0;
  int       failures = 0;

  // Reference model: mode 0 idle, 1 run, 2 done, 3 err.
  int     m_mode = 0;
  longint m_num = 1, m_den = 1, m_burst = 0, m_k = 0, m_bcnt = 0, m_cnt = 0;
  logic   e_ena = 1'b0, e_done = 1'b0;
  logic   rst_d = 1'b1;

  task automatic model_reset();
    m_mode = 0; m_num = 1; m_den = 1; m_burst = 0;
    m_k = 0; m_bcnt = 0; m_cnt = 0; e_ena = 1'b0; e_done = 1'b0;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.ena  = e_ena;
    e.busy = (m_mode == 1);
    e.err  = (m_mode == 3);
    e.done = e_done;
    e.cnt  = CNT_W'(m_cnt);
    return e;
  endfunction

  task automatic model_step();
    e_ena = 1'b0; e_done = 1'b0;
    if (cfg_load) begin
      m_num = longint'(cfg_num); m_den = longint'(cfg_den); m_burst = longint'(cfg_burst);
      m_k = 0; m_bcnt = 0; m_cnt = 0;
      if (m_den == 0 || m_num > m_den) m_mode = 3;
      else if (m_mode == 1 && run)     m_mode = 1;
      else                             m_mode = 0;
    end else begin
      case (m_mode)
        0: if (run) begin m_mode = 1; m_k = 0; m_bcnt = 0; end
        1: begin
          if (!run) m_mode = 0;
          else begin
            m_k++;
            // Strobe whenever floor(k*num/den) advances.
            e_ena = ((m_k * m_num) / m_den) != (((m_k - 1) * m_num) / m_den);
            if (e_ena) begin m_cnt++; m_bcnt++; end
`ifdef ENA_GEN_BURST_EN
            if (e_ena && m_burst != 0 && m_bcnt == m_burst) begin m_mode = 2; e_done = 1'b1; end
`endif
          end
        end
        2: if (!run) m_mode = 0;
        default: ;
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst && !rst_d) begin
      model_reset();
      if (sb_q.size() > 0) sb_q[sb_q.size()-1] = model_out();
    end else if (rst) begin
      model_reset();
      sb_q.push_back(model_out());
    end else begin
      model_step();
      sb_q.push_back(model_out());
    end
    rst_d = rst;
  end

  initial forever begin
    exp_t     e;
    cnt_chk_t c;
    @(negedge clk);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if ({ena, busy, err, done, cnt} !== e) begin
        failures++;
        $display("FAIL outputs t=%0t got ena=%b busy=%b err=%b done=%b cnt=%0d want ena=%b busy=%b err=%b done=%b cnt=%0d",
                 $time, ena, busy, err, done, cnt, e.ena, e.busy, e.err, e.done, e.cnt);
      end
    end
    if (xq.size() > 0) begin
      c = xq.pop_front();
      checks++;
      if (longint'(cnt) != c.want) begin
        failures++;
        $display("FAIL strobe_cnt_%0d got=%0d want=%0d", c.id, cnt, c.want);
      end
    end
    if (busy && m_mode == 1) begin
      checks++;
      if (longint'(dut.u_acc.acc) >= m_den) begin
        failures++;
        $display("FAIL acc_bound t=%0t acc=%0d den=%0d", $time, dut.u_acc.acc, m_den);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic do_load(input int n, input int d, input int b);
    cfg_num = ACC_W'(n); cfg_den = ACC_W'(d); cfg_burst = 16'(b);
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic expect_cnt(input int id, input longint v);
    cnt_chk_t c;
    c.want = v; c.id = id;
    xq.push_back(c);
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    tick();

    // Full rate
    do_load(1, 1, 0); run = 1'b1; tick();
    repeat (100) tick();
    expect_cnt(1, 100);
    run = 1'b0; tick(); tick();

    // 3/8 rate
    do_load(3, 8, 0); run = 1'b1; tick();
    repeat (80) tick();
    expect_cnt(2, 30);
    run = 1'b0; tick();

    // Invalid config then recovery
    run = 1'b1;
    do_load(5, 4, 0);
    repeat (10) tick();
    do_load(1, 4, 0);
    repeat (21) tick();
    expect_cnt(3, 5);
    run = 1'b0; tick();

    // Reload while running
    do_load(1, 2, 0); run = 1'b1; tick();
    repeat (9) tick();
    do_load(1, 3, 0);
    expect_cnt(4, 0);
    repeat (12) tick();
    expect_cnt(5, 4);
    run = 1'b0; tick();

    // Burst
    do_load(1, 2, 5); run = 1'b1; tick();
    repeat (20) tick();
`ifdef ENA_GEN_BURST_EN
    expect_cnt(6, 5);
`else
    expect_cnt(6, 10);
`endif
    run = 1'b0; tick(); run = 1'b1; tick();
    repeat (4) tick();
    run = 1'b0; tick();

    // Asynchronous reset while running
    do_load(1, 2, 3); run = 1'b1; tick();
    repeat (3) tick();
    rst = 1'b1;
    expect_cnt(7, 0);
    tick();
    rst = 1'b0;
    repeat (10) tick();
    expect_cnt(8, 9);
    run = 1'b0; tick();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        do_load(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)), int'($urandom_range(0, 5)));
      end else if ($urandom_range(0, 149) == 0) begin
        rst = 1'b1; tick(); rst = 1'b0;
      end else begin
        if ($urandom_range(0, 11) == 0) run = ~run;
        tick();
      end
    end

    run = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
